arb_request_master: RTL and testbench

ARB_REQUEST_MASTER -- requirements
Module: arb_request_master

---
 rtl/arb_req_pkg.sv | 20 ++
 rtl/arb_req_chan.sv | 110 +++++++++++
 rtl/arb_request_master.sv | 56 +++++
 tb/tb_arb_request_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_req_pkg.sv
// arb_req_pkg: shared channel state encoding and default sizing for arb_request_master.
package arb_req_pkg;

    localparam int N_DEF          = 4;
    localparam int DEPTH_DEF      = 7;
    localparam int HOLD_DEF       = 2;
    localparam int WDOG_LIMIT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_OWN,
        ST_REL
    } chan_st_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/arb_req_chan.sv
// arb_req_chan: one requester channel (pending counter, hold counter, IDLE/REQ/OWN/REL FSM).
// Optional starvation watchdog compiled in with ARB_REQ_WDOG_EN.
module arb_req_chan
    import arb_req_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int HOLD       = HOLD_DEF,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  logic i_gnt,
    output logic o_req,
    output logic o_busy,
    output logic o_done,
    output logic o_ovf,
    output logic o_rel,
    output logic o_starve
);

    localparam int CW = cnt_width(DEPTH);
    localparam int HW = $clog2(HOLD + 1);

    if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
        $error("arb_req_chan: HOLD must be within 1..15");
    end
    if (WDOG_LIMIT < 1) begin : g_bad_wdog
        $error("arb_req_chan: WDOG_LIMIT must be positive");
    end

    chan_st_t        r_st, w_st_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [HW-1:0]   r_hold, w_hold_nxt;
    logic            r_req, r_done, r_ovf;
    logic            w_dec, w_drop;

    // A finishing transaction and a new push cancel out, so a full channel still accepts it.
    assign w_dec     = (r_st == ST_OWN) && (r_hold == HW'(HOLD));
    assign w_drop    = i_push && !w_dec && (r_cnt == CW'(DEPTH));
    assign w_cnt_nxt = (i_push == w_dec || w_drop) ? r_cnt :
                       i_push ? r_cnt + 1'b1 : r_cnt - 1'b1;

    always_comb begin
        w_st_nxt   = r_st;
        w_hold_nxt = r_hold;
        case (r_st)
            ST_IDLE: w_st_nxt = (w_cnt_nxt != '0) ? ST_REQ : ST_IDLE;
            ST_REQ: begin
                w_st_nxt   = i_gnt ? ST_OWN : ST_REQ;
                w_hold_nxt = i_gnt ? HW'(1) : '0;
            end
            ST_OWN: begin
                w_st_nxt   = w_dec ? ST_REL : i_gnt ? ST_OWN : ST_REQ;
                w_hold_nxt = (!w_dec && i_gnt) ? r_hold + 1'b1 : '0;
            end
            ST_REL: w_st_nxt = (w_cnt_nxt != '0) ? ST_REQ : ST_IDLE;
            default: w_st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st   <= ST_IDLE;
            r_cnt  <= '0;
            r_hold <= '0;
            r_req  <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_st   <= w_st_nxt;
            r_cnt  <= w_cnt_nxt;
            r_hold <= w_hold_nxt;
            r_req  <= (w_st_nxt == ST_REQ) || (w_st_nxt == ST_OWN);
            r_done <= w_dec;
            r_ovf  <= r_ovf | w_drop;
        end
    end

    assign o_req  = r_req;
    assign o_busy = (r_st == ST_OWN);
    assign o_done = r_done;
    assign o_ovf  = r_ovf;
    assign o_rel  = (r_st == ST_REL);

`ifdef ARB_REQ_WDOG_EN
    localparam int WW = $clog2(WDOG_LIMIT + 1);

    logic [WW-1:0] r_wait, w_wait_nxt;
    logic          r_starve;

    assign w_wait_nxt = (r_st != ST_REQ) ? '0 :
                        (r_wait == WW'(WDOG_LIMIT)) ? r_wait : r_wait + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait   <= '0;
            r_starve <= 1'b0;
        end else begin
            r_wait   <= w_wait_nxt;
            r_starve <= r_starve | (w_wait_nxt == WW'(WDOG_LIMIT));
        end
    end

    assign o_starve = r_starve;
`else
    assign o_starve = 1'b0;
`endif

endmodule

// File: rtl/arb_request_master.sv
// arb_request_master: N independent request channels facing a fixed-priority arbiter, plus grant checking.
// Define ARB_REQ_WDOG_EN to enable the per-channel starvation watchdog.
module arb_request_master
    import arb_req_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int HOLD       = HOLD_DEF,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] push,
    input  logic [N-1:0] GNT,
    output logic [N-1:0] REQ,
    output logic [N-1:0] busy,
    output logic [N-1:0] done,
    output logic [N-1:0] ovf,
    output logic         proto_err,
    output logic [N-1:0] starve
);

    logic [N-1:0] w_rel;
    logic         w_bad;
    logic         r_perr;

    for (genvar i = 0; i < N; i++) begin : g_chan
        arb_req_chan #(
            .DEPTH      (DEPTH),
            .HOLD       (HOLD),
            .WDOG_LIMIT (WDOG_LIMIT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_push   (push[i]),
            .i_gnt    (GNT[i]),
            .o_req    (REQ[i]),
            .o_busy   (busy[i]),
            .o_done   (done[i]),
            .o_ovf    (ovf[i]),
            .o_rel    (w_rel[i]),
            .o_starve (starve[i])
        );
    end

    // A late grant landing on a releasing channel is tolerated; anything else unrequested is an error.
    assign w_bad = ($countones(GNT) > 1) || (|(GNT & ~REQ & ~w_rel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_perr <= 1'b0;
        else        r_perr <= r_perr | w_bad;
    end

    assign proto_err = r_perr;

endmodule

// File: tb/tb_arb_request_master.sv
// tb_arb_request_master: directed scenarios plus randomized traffic against a transaction-level model.
module tb_arb_request_master;

    localparam int N     = 4;
    localparam int DEPTH = 7;
    localparam int HOLD  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] push = '0;
    logic [N-1:0] gnt = '0;
    logic [N-1:0] REQ, busy, done, ovf, starve;
    logic         proto_err;

    always #5 clk = ~clk;

    arb_request_master #(
        .N          (N),
        .DEPTH      (DEPTH),
        .HOLD       (HOLD),
        .WDOG_LIMIT (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .GNT       (gnt),
        .REQ       (REQ),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .proto_err (proto_err),
        .starve    (starve)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: pending work, granted cycles owned so far, and a one-cycle release marker per channel.
    int           m_pend [N];
    int           m_own  [N];
    logic [N-1:0] m_rel, m_ovf, m_done;
    logic         m_perr;

    int n_busy [N];
    int n_done [N];
    int first_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_req();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_pend[i] > 0) && !m_rel[i];
        return r;
    endfunction

    function automatic logic [N-1:0] m_busy();
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = (m_own[i] > 0);
        return b;
    endfunction

    function automatic logic [N-1:0] arb(input logic [N-1:0] r);
        logic [N-1:0] g;
        g = '0;
        for (int i = 0; i < N; i++) if (r[i]) begin
            g = '0;
            g[i] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_own[i]  = 0;
            n_busy[i] = 0;
            n_done[i] = 0;
        end
        m_rel = '0;
        m_ovf = '0;
        m_done = '0;
        m_perr = 1'b0;
        first_done = -1;
    endtask

    task automatic step(input logic [N-1:0] p, input logic [N-1:0] g);
        logic [N-1:0] r;
        r = m_req();
        if ($countones(g) > 1 || (g & ~r & ~m_rel) != '0) m_perr = 1'b1;
        for (int i = 0; i < N; i++) begin
            bit fin;
            fin = (m_own[i] >= HOLD);
            if (fin) m_own[i] = 0;
            else if (m_own[i] > 0) m_own[i] = g[i] ? m_own[i] + 1 : 0;
            else if (r[i] && g[i]) m_own[i] = 1;
            if (p[i] && !fin && m_pend[i] == DEPTH) m_ovf[i] = 1'b1;
            else m_pend[i] = m_pend[i] + int'(p[i]) - int'(fin);
            m_rel[i]  = fin;
            m_done[i] = fin;
        end
    endtask

    task automatic check_all();
        chk("req", REQ, m_req());
        chk("busy", busy, m_busy());
        chk("done", done, m_done);
        chk("ovf", ovf, m_ovf);
        chk("proto_err", proto_err, m_perr);
        chk("starve", starve, 0);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic cycle(input logic [N-1:0] p, input logic [N-1:0] g);
        push = p;
        gnt  = g;
        step(p, g);
        @(negedge clk);
        check_all();
        for (int i = 0; i < N; i++) begin
            n_busy[i] += int'(busy[i]);
            n_done[i] += int'(done[i]);
            if (first_done < 0 && done[i]) first_done = i;
        end
    endtask

    task automatic arb_run(input int n);
        repeat (n) cycle('0, arb(m_req()));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        push  = '0;
        gnt   = '0;
        #1;
        chk("rst_req", REQ, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_starve", starve, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] p, g;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        do_reset();
        cycle(4'b1000, '0);
        arb_run(6);
        chk("s1_busy_cycles", n_busy[3], HOLD);
        chk("s1_done_count", n_done[3], 1);
        chk("s1_req_idle", REQ, 0);

        do_reset();
        cycle(4'b1010, '0);
        arb_run(12);
        chk("s2_first_done", first_done, 3);
        chk("s2_done1", n_done[1], 1);
        chk("s2_done3", n_done[3], 1);

        do_reset();
        repeat (8) cycle(4'b0001, '0);
        chk("s3_ovf", ovf, 4'b0001);
        arb_run(40);
        chk("s3_drained", n_done[0], DEPTH);

        do_reset();
        cycle(4'b0100, '0);
        cycle('0, 4'b0100);
        cycle('0, '0);
        chk("s4_req2", REQ[2], 1);
        chk("s4_busy2", busy[2], 0);
        chk("s4_no_done", n_done[2], 0);
        arb_run(8);
        chk("s4_done_after", n_done[2], 1);

        do_reset();
        cycle('0, 4'b0110);
        repeat (3) cycle('0, '0);
        chk("s5_perr_sticky", proto_err, 1);

        do_reset();
        cycle(4'b0001, '0);
        cycle('0, 4'b0001);
        chk("s6_busy0", busy[0], 1);
        do_reset();
        repeat (3) cycle('0, '0);
        chk("s6_no_done", n_done[0], 0);

        for (int e = 0; e < 4; e++) begin
            do_reset();
            repeat (400) begin
                for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 3) == 0);
                g = arb(m_req());
                if ($urandom_range(0, 9) == 0) g = '0;
                if (m_rel != '0 && $urandom_range(0, 4) == 0) g = arb(m_rel);
                if (e == 3 && $urandom_range(0, 49) == 0) g = N'($urandom_range(0, 15));
                cycle(p, g);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
